// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: prescaled pixel tick, h/v counters and a registered decode
// stage producing sync, display-active, pixel coordinates and line/frame start pulses.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned H_POL    = 0,
  parameter int unsigned V_POL    = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        disp_active_o,
  output logic [10:0] xcol_o,
  output logic [10:0] yrow_o,
  output logic        pix_tick_o,
  output logic        line_start_o,
  output logic        frame_start_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic        H_LVL    = (H_POL != 0);
  localparam logic        V_LVL    = (V_POL != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d;
  logic [10:0]      v_q, v_d;
  logic             div_wrap;

  // Comparisons are done at 12 bits so a bound equal to 2048 stays representable.
  logic [11:0] h_ext, v_ext;
  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  always_comb begin
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;
    div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
    if (div_wrap) begin
      div_d = '0;
      if (h_q == 11'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == 11'(V_TOTAL - 1)) ? 11'd0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  logic        hsync_d, vsync_d, disp_d, tick_d, line_d, frame_d;

  always_comb begin
    hsync_d = ~H_LVL;
    vsync_d = ~V_LVL;
    if (h_ext >= 12'(HS_START) && h_ext < 12'(HS_END)) hsync_d = H_LVL;
    if (v_ext >= 12'(VS_START) && v_ext < 12'(VS_END)) vsync_d = V_LVL;
    disp_d  = (h_ext < 12'(H_ACTIVE)) && (v_ext < 12'(V_ACTIVE));
    tick_d  = (div_q == '0);
    line_d  = tick_d && (h_q == '0);
    frame_d = line_d && (v_q == '0);
  end

  // Output stage: registered decode of the current counters, one clk behind them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_o       <= ~H_LVL;
      vsync_o       <= ~V_LVL;
      disp_active_o <= 1'b0;
      xcol_o        <= '0;
      yrow_o        <= '0;
      pix_tick_o    <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      hsync_o       <= hsync_d;
      vsync_o       <= vsync_d;
      disp_active_o <= disp_d;
      xcol_o        <= h_q;
      yrow_o        <= v_q;
      pix_tick_o    <= tick_d;
      line_start_o  <= line_d;
      frame_start_o <= frame_d;
    end
  end

endmodule
